// File: rtl/shift_register_pkg.sv
// shift_register_pkg: mode encoding and fill-counter width helper for shift_register_bank
package shift_register_pkg;
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOAD  = 3'd1,
        SHL   = 3'd2,
        SHR   = 3'd3,
        ROTL  = 3'd4,
        ROTR  = 3'd5,
        CLEAR = 3'd6,
        RSVD  = 3'd7
    } sr_mode_t;

    function automatic int FILL_W(input int depth);
        return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ff_stage.sv
// ff_stage: one WIDTH-bit register with enable and synchronous reset
module ff_stage #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= RESET_VAL;
        else if (en) q <= d;
    end
endmodule

// File: rtl/shift_register_bank.sv
// shift_register_bank: DEPTH x WIDTH register bank with load, shift, rotate, clear and a saturating fill count
module shift_register_bank
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [2:0]                  mode,
    input  logic [WIDTH-1:0]            ser_in,
    input  logic [DEPTH*WIDTH-1:0]      par_in,
    output logic [DEPTH*WIDTH-1:0]      par_out,
    output logic [WIDTH-1:0]            ser_out_l,
    output logic [WIDTH-1:0]            ser_out_r,
    output logic [FILL_W(DEPTH)-1:0]    fill,
    output logic                        full
);
    localparam int FW = FILL_W(DEPTH);

    sr_mode_t         op;
    logic             stage_en;
    logic [WIDTH-1:0] q [DEPTH];

    assign op       = sr_mode_t'(mode);
    assign stage_en = en && (op inside {LOAD, SHL, SHR, ROTL, ROTR, CLEAR});

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] from_l, from_r, d;
        // End stages take ser_in on shifts and wrap around on rotates
        if (i == 0) begin : g_l_end
            assign from_l = (op == ROTL) ? q[DEPTH-1] : ser_in;
        end else begin : g_l_mid
            assign from_l = q[i-1];
        end
        if (i == DEPTH - 1) begin : g_r_end
            assign from_r = (op == ROTR) ? q[0] : ser_in;
        end else begin : g_r_mid
            assign from_r = q[i+1];
        end
        assign d = (op == LOAD) ? par_in[i*WIDTH +: WIDTH] :
                   (op == SHL || op == ROTL) ? from_l :
                   (op == SHR || op == ROTR) ? from_r : RESET_VAL;
        ff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (stage_en),
            .d     (d),
            .q     (q[i])
        );
        assign par_out[i*WIDTH +: WIDTH] = q[i];
    end

    assign ser_out_l = q[DEPTH-1];
    assign ser_out_r = q[0];
    assign full      = (fill == FW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) fill <= '0;
        else if (en) begin
            if (op == LOAD) fill <= FW'(DEPTH);
            else if ((op == SHL || op == SHR) && !full) fill <= fill + FW'(1);
            else if (op == CLEAR) fill <= '0;
        end
    end
endmodule

// File: tb/tb_shift_register_bank.sv
// tb_shift_register_bank: directed and random checks of a 4x8 bank and a 1x4 bank against a word-level model
module tb_shift_register_bank;
    logic        clk = 1'b0;
    logic        reset, en;
    logic [2:0]  mode;
    logic [7:0]  ser_in;
    logic [31:0] par_in;
    logic [31:0] par_out;
    logic [7:0]  ser_out_l, ser_out_r;
    logic [2:0]  fill;
    logic        full;
    logic [3:0]  b_out, b_sol, b_sor;
    logic [0:0]  b_fill;
    logic        b_full;

    logic [31:0] mv;
    int          mf;
    logic [3:0]  bv;
    int          bf;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    shift_register_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in), .par_in(par_in),
        .par_out(par_out), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r), .fill(fill), .full(full)
    );

    shift_register_bank #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'hA)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in[3:0]), .par_in(par_in[3:0]),
        .par_out(b_out), .ser_out_l(b_sol), .ser_out_r(b_sor), .fill(b_fill), .full(b_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle, advance the word-level model, compare every output of both banks
    task automatic step(input logic r, input logic e, input logic [2:0] md,
                        input logic [7:0] s, input logic [31:0] p);
        reset = r; en = e; mode = md; ser_in = s; par_in = p;
        @(posedge clk);
        #1;
        if (r) begin
            mv = '0; mf = 0; bv = 4'hA; bf = 0;
        end else if (e) begin
            case (md)
                3'd1: begin mv = p; mf = 4; bv = p[3:0]; bf = 1; end
                3'd2: begin mv = {mv[23:0], s}; mf = (mf < 4) ? mf + 1 : 4; bv = s[3:0]; bf = 1; end
                3'd3: begin mv = {s, mv[31:8]}; mf = (mf < 4) ? mf + 1 : 4; bv = s[3:0]; bf = 1; end
                3'd4: mv = {mv[23:0], mv[31:24]};
                3'd5: mv = {mv[7:0], mv[31:8]};
                3'd6: begin mv = '0; mf = 0; bv = 4'hA; bf = 0; end
                default: ;
            endcase
        end
        chk("par_out", par_out, mv);
        chk("ser_out_l", {24'h0, ser_out_l}, {24'h0, mv[31:24]});
        chk("ser_out_r", {24'h0, ser_out_r}, {24'h0, mv[7:0]});
        chk("fill", {29'h0, fill}, mf);
        chk("full", {31'h0, full}, {31'h0, mf == 4});
        chk("d1_stage", {28'h0, b_out}, {28'h0, bv});
        chk("d1_ser", {24'h0, b_sol, b_sor}, {24'h0, bv, bv});
        chk("d1_fill_full", {30'h0, b_fill, b_full}, {30'h0, bf[0], bf == 1});
    endtask

    initial begin
        mv = '0; mf = 0; bv = 4'hA; bf = 0;
        for (int k = 0; k < 5; k++) step(1, 0, 3'd0, 8'h00, 32'h0);
        step(0, 1, 3'd0, 8'h00, 32'h0);
        chk("reset_par_out", par_out, 32'h0);
        chk("reset_fill_full", {28'h0, fill, full}, 32'h0);
        chk("reset_d1", {28'h0, b_out}, 32'hA);

        for (int k = 0; k < 5; k++) begin
            step(0, 1, 3'd2, 8'(8'h11 * (k + 1)), 32'h0);
            chk("fill_seq", {29'h0, fill}, (k < 3) ? k + 1 : 4);
            chk("full_seq", {31'h0, full}, {31'h0, k >= 3});
        end
        chk("serial_par_out", par_out, 32'h22334455);
        chk("serial_ser_out_l", {24'h0, ser_out_l}, 32'h22);

        step(0, 1, 3'd1, 8'h00, 32'h44332211);
        chk("load_fill", {29'h0, fill}, 32'd4);
        step(0, 1, 3'd4, 8'h00, 32'h0);
        chk("rotl", par_out, 32'h33221144);
        step(0, 1, 3'd5, 8'h00, 32'h0);
        step(0, 1, 3'd5, 8'h00, 32'h0);
        chk("rotr2", par_out, 32'h11443322);
        chk("rotr_fill", {29'h0, fill}, 32'd4);

        for (int k = 0; k < 3; k++) step(0, 0, 3'd3, 8'hEE, 32'hDEADBEEF);
        step(0, 1, 3'd7, 8'hEE, 32'hDEADBEEF);
        chk("gated_hold", par_out, 32'h11443322);

        step(0, 1, 3'd6, 8'h00, 32'h0);
        chk("clear", {par_out[28:0], fill}, 32'h0);
        step(0, 1, 3'd3, 8'h5A, 32'h0);
        step(0, 1, 3'd3, 8'hA5, 32'h0);
        step(1, 1, 3'd3, 8'hC3, 32'h0);
        chk("mid_reset", {par_out[28:0], fill}, 32'h0);

        step(1, 0, 3'd0, 8'h00, 32'h0);
        chk("d1_reset", {28'h0, b_out}, 32'hA);
        step(0, 1, 3'd3, 8'h03, 32'h0);
        chk("d1_shr", {27'h0, b_out, b_full}, {27'h0, 4'h3, 1'b1});
        step(0, 1, 3'd4, 8'h00, 32'h0);
        chk("d1_rotl", {28'h0, b_out}, 32'h3);

        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 32'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_register_bank.md
# shift_register_bank

Parametrised multi-stage register bank that generalises the single D flip-flop. It holds DEPTH words of WIDTH bits and supports hold, parallel load, shift left/right, rotate left/right and clear, with a saturating fill counter. It sits between serial producers and parallel consumers (deserialiser, delay line, sample window) in datapath blocks.

## Interface
Parameters:
- WIDTH, 8, bits per stage; must be at least 1
- DEPTH, 4, number of stages; must be at least 1
- RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset and on CLEAR

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high
- en  input  1  operation enable; when low the bank holds regardless of mode
- mode  input  3  operation select (sr_mode_t)
- ser_in  input  WIDTH  word shifted in on SHL/SHR
- par_in  input  DEPTH*WIDTH  parallel load data; stage i = par_in[i*WIDTH +: WIDTH]
- par_out  output  DEPTH*WIDTH  current stage contents, same packing as par_in
- ser_out_l  output  WIDTH  stage DEPTH-1 (the word shifted out by SHL)
- ser_out_r  output  WIDTH  stage 0 (the word shifted out by SHR)
- fill  output  $clog2(DEPTH+1)  number of valid words, 0..DEPTH
- full  output  1  fill == DEPTH

## Operation
Modes (sr_mode_t):
- HOLD=0: no change
- LOAD=1: stage[i] <= par_in slice i; fill <= DEPTH
- SHL=2: stage[i] <= stage[i-1] for i>0; stage[0] <= ser_in; fill <= min(fill+1, DEPTH)
- SHR=3: stage[i] <= stage[i+1] for i<DEPTH-1; stage[DEPTH-1] <= ser_in; fill <= min(fill+1, DEPTH)
- ROTL=4: stage[i] <= stage[i-1]; stage[0] <= stage[DEPTH-1]; fill unchanged
- ROTR=5: stage[i] <= stage[i+1]; stage[DEPTH-1] <= stage[0]; fill unchanged
- CLEAR=6: all stages <= RESET_VAL; fill <= 0
- 7 (reserved): behaves as HOLD

Rules:
- Priority: reset > en low > mode.
- Reset: all stages = RESET_VAL, fill = 0, full = 0.
- The fill counter saturates at DEPTH and never wraps. full stays asserted while further shifts occur.
- The fill counter never underflows; no mode decrements it.
- DEPTH=1: SHL and SHR both load ser_in into stage 0. ROTL and ROTR behave as HOLD.
- Outputs par_out, ser_out_l and ser_out_r are driven directly from the stage registers, with no extra combinational path from the inputs.

## Timing
- All state updates on the rising edge of clk. Single-cycle latency: an op sampled at edge N is visible on outputs after edge N.
- Reset takes effect at the first rising edge with reset high. Asserting reset in the middle of a shift sequence discards the sequence; the next cycle shows reset values.
- A change on mode or en takes effect at the next edge. There is no handshake.
- full is a registered compare, or a compare of the registered fill; in either case it is glitch-free relative to clk.

## Structure
- Package shift_register_pkg holds sr_mode_t (3-bit enum, values as above) and a FILL_W helper function that computes $clog2(DEPTH+1), with a minimum of 1.
- Sub-module ff_stage (WIDTH, RESET_VAL): one WIDTH-bit register with en, d and synchronous reset.
  - The top level instantiates DEPTH ff_stage instances in a generate loop.
  - A per-stage next-value mux selects the stage input from mode.
  - The fill counter is implemented in the top level.

## Test plan
- Reset: with WIDTH=8, DEPTH=4, RESET_VAL=0, hold reset for 5 cycles, then release -> par_out=0, fill=0, full=0.
- Serial fill: apply SHL with ser_in=0x11, 0x22, 0x33, 0x44, 0x55 on 5 consecutive cycles -> fill goes 1,2,3,4,4; final stages[3:0]=0x22,0x33,0x44,0x55; ser_out_l=0x22; full=1 from cycle 4 onward.
- Load and rotate:
  - LOAD par_in=0x44332211 -> fill=4.
  - Then ROTL -> par_out=0x33221144.
  - Then ROTR twice -> par_out=0x11443322; fill remains 4.
- Enable gating and reserved mode: with en=0 and mode=SHR for 3 cycles -> no change. mode=7 with en=1 -> no change.
- Clear and reset mid-operation:
  - CLEAR -> par_out=0, fill=0.
  - During an SHR sequence, assert reset for 1 cycle -> next cycle par_out=RESET_VAL replicated and fill=0, with no partial shift.
- Boundary DEPTH=1, WIDTH=4, RESET_VAL=0xA:
  - Reset -> stage=0xA.
  - SHR with ser_in=0x3 -> stage=0x3, full=1.
  - ROTL -> stage=0x3.
